// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a valid/ready byte stream (high byte first)
// into 16-bit words written to consecutive even addresses, holding the CPU off.
module imem_loader #(
  parameter int unsigned NUM_WORDS = 8,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic [15:0]       checksum
);

  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic [15:0]       r_checksum;
  logic              w_last;
  logic              w_busy;

  // Counter still holds the pre-increment value during WRITE.
  assign w_last = (r_cnt == CNT_W'(NUM_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start)    w_next = S_HI;
      S_HI:           if (in_valid) w_next = S_LO;
      S_LO:           if (in_valid) w_next = S_WRITE;
      S_WRITE:        w_next = w_last ? S_DONE : S_HI;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_checksum <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_checksum <= '0;
          end
        end
        S_HI: if (in_valid) r_wdata[15:8] <= in_data;
        S_LO: if (in_valid) r_wdata[7:0]  <= in_data;
        S_WRITE: begin
          r_checksum <= r_checksum ^ r_wdata;
          r_cnt      <= r_cnt + CNT_W'(1);
          if (!w_last) r_addr <= r_addr + ADDR_W'(2);
        end
        default: ;
      endcase
    end
  end

  assign w_busy    = (r_state == S_HI) || (r_state == S_LO) || (r_state == S_WRITE);
  assign in_ready  = (r_state == S_HI) || (r_state == S_LO);
  assign mem_we    = (r_state == S_WRITE);
  assign busy      = w_busy;
  assign cpu_hold  = w_busy;
  assign done      = (r_state == S_DONE);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign checksum  = r_checksum;

endmodule
